// File: rtl/solar_monitor_mc.sv
// Multi-channel solar panel monitor: per-channel windowed mean or peak-hold,
// with a sticky low-output fault raised after FAULT_CNT consecutive low windows.
module solar_monitor_mc #(
  parameter int NCH       = 4,
  parameter int SW        = 8,
  parameter int AVG_LOG2  = 2,
  parameter int FAULT_CNT = 3,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_ni,
  input  logic              sample_valid_i,
  input  logic [CW-1:0]     sample_ch_i,
  input  logic [SW-1:0]     sample_i,
  input  logic              mode_i,
  input  logic [SW-1:0]     thresh_i,
  input  logic [NCH-1:0]    clear_i,
  output logic [NCH*SW-1:0] result_o,
  output logic              done_o,
  output logic [CW-1:0]     done_ch_o,
  output logic [NCH-1:0]    fault_o,
  output logic              any_fault_o
);

  localparam int AW                 = SW + AVG_LOG2;  // wide enough for a full window sum
  localparam int NW                 = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NW-1:0] LAST_CNT = NW'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] FAULT_MAX  = 4'(FAULT_CNT);

  // Per-channel state
  logic [AW-1:0]  r_acc    [NCH];
  logic [SW-1:0]  r_peak   [NCH];
  logic [NW-1:0]  r_cnt    [NCH];
  logic [SW-1:0]  r_result [NCH];
  logic [3:0]     r_low    [NCH];
  logic [NCH-1:0] r_mode;
  logic [NCH-1:0] r_fault;
  logic           r_done;
  logic [CW-1:0]  r_done_ch;

  // Next-state helpers
  logic [NCH-1:0] w_hit, w_last, w_mode, w_set;
  logic [AW-1:0]  w_sum      [NCH];
  logic [SW-1:0]  w_peak     [NCH];
  logic [SW-1:0]  w_res      [NCH];
  logic [3:0]     w_low_next [NCH];
  logic [CW-1:0]  w_done_ch;

  // Decode the sample to its channel and precompute each channel's window update
  always_comb begin
    w_done_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      // Out-of-range channel indices match no k, so they are silently dropped.
      w_hit[k]  = sample_valid_i && (sample_ch_i == CW'(k));
      w_last[k] = w_hit[k] && (r_cnt[k] == LAST_CNT);
      // The first sample of a window sees mode_i directly; later ones use the latch.
      w_mode[k] = (r_cnt[k] == '0) ? mode_i : r_mode[k];
      w_sum[k]  = r_acc[k] + AW'(sample_i);
      w_peak[k] = (sample_i > r_peak[k]) ? sample_i : r_peak[k];
      w_res[k]  = w_mode[k] ? w_peak[k] : SW'(w_sum[k] >> AVG_LOG2);
      if (w_res[k] < thresh_i)
        w_low_next[k] = (r_low[k] >= FAULT_MAX) ? FAULT_MAX : r_low[k] + 4'd1;
      else
        w_low_next[k] = '0;
      w_set[k] = w_last[k] && (w_low_next[k] == FAULT_MAX);
      if (w_last[k]) w_done_ch = CW'(k);
    end
  end

  // Accumulate samples, close windows and publish results
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      // NOTE: per-channel arrays are cleared by reset, so they must stay flip-flops
      // (a RAM cannot clear every entry asynchronously).
      for (int k = 0; k < NCH; k++) begin
        r_acc[k]    <= '0;
        r_peak[k]   <= '0;
        r_cnt[k]    <= '0;
        r_result[k] <= '0;
      end
      r_mode    <= '0;
      r_done    <= 1'b0;
      r_done_ch <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every channel reading pre-edge state.
      r_done <= |w_last;
      if (|w_last) r_done_ch <= w_done_ch;
      for (int k = 0; k < NCH; k++) begin
        if (w_hit[k]) begin
          if (r_cnt[k] == '0) r_mode[k] <= mode_i;
          if (w_last[k]) begin
            r_acc[k]    <= '0;
            r_peak[k]   <= '0;
            r_cnt[k]    <= '0;
            r_result[k] <= w_res[k];
          end else begin
            r_acc[k]  <= w_sum[k];
            r_peak[k] <= w_peak[k];
            r_cnt[k]  <= r_cnt[k] + NW'(1);
          end
        end
      end
    end
  end

  // Track consecutive low windows and the sticky fault; a setting window beats clear
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int k = 0; k < NCH; k++) r_low[k] <= '0;
      r_fault <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (w_set[k]) begin
          r_fault[k] <= 1'b1;
          r_low[k]   <= FAULT_MAX;
        end else if (clear_i[k]) begin
          r_fault[k] <= 1'b0;
          r_low[k]   <= '0;
        end else if (w_last[k]) begin
          r_low[k] <= w_low_next[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NCH; k++) begin : g_result
    assign result_o[k*SW +: SW] = r_result[k];
  end

  assign done_o      = r_done;
  assign done_ch_o   = r_done_ch;
  assign fault_o     = r_fault;
  assign any_fault_o = |r_fault;

endmodule
